// File: rtl/ddr5_axi_traffic_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr5_axi_traffic_gen_if
// Purpose  : Host-port bundle between the traffic generator and the DDR5
//            controller (write request, read address, read data channels).
// Ports    : master = generator side, slave = controller / memory side.
//            W_Valid/W_Data/W_STRB/W_Address/W_Ready        write channel
//            R_Valid_Address/R_Address/R_Ready_Address      read address
//            R_Valid/R_Data/R_Error/R_Ready                 read data
// Revision : 1.0  initial release
// ============================================================================
interface ddr5_axi_traffic_gen_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();
  logic                  W_Valid;
  logic [DATA_W-1:0]     W_Data;
  logic [DATA_W/8-1:0]   W_STRB;
  logic [ADDR_W-1:0]     W_Address;
  logic                  W_Ready;
  logic                  R_Valid_Address;
  logic [ADDR_W-1:0]     R_Address;
  logic                  R_Ready_Address;
  logic                  R_Valid;
  logic [DATA_W-1:0]     R_Data;
  logic                  R_Error;
  logic                  R_Ready;

  modport master (
    output W_Valid, W_Data, W_STRB, W_Address,
    input  W_Ready,
    output R_Valid_Address, R_Address,
    input  R_Ready_Address,
    input  R_Valid, R_Data, R_Error,
    output R_Ready
  );

  modport slave (
    input  W_Valid, W_Data, W_STRB, W_Address,
    output W_Ready,
    input  R_Valid_Address, R_Address,
    output R_Ready_Address,
    output R_Valid, R_Data, R_Error,
    input  R_Ready
  );
endinterface
`default_nettype wire

// File: rtl/ddr5_axi_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : ddr5_axi_traffic_gen
// Purpose  : Write-then-read traffic generator and checker for the DDR5
//            controller host port. Writes NUM_TXN pattern words, reads every
//            address back and counts mismatches, read errors and timeouts.
// Ports    : axi_clk   - sole clock, rising edge
//            rst_n     - synchronous reset, active low
//            start     - one-cycle pulse, begins a run when idle/done
//            bus       - host-port bundle (master modport)
//            busy/done/pass/err_count/txn_idx - run status
// Options  : TG_ERR_INJECT_EN - when defined, write index 0 carries W_Data
//            bit 0 inverted while the checker still expects the clean word.
// Revision : 1.0  initial release
// ============================================================================
module ddr5_axi_traffic_gen #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       NUM_TXN     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_4567,
  parameter logic [ADDR_W-1:0] ADDR_STRIDE = 32'h0000_0001,
  parameter logic [DATA_W-1:0] PAT_SEED    = 32'h1425_3679,
  parameter logic [DATA_W-1:0] PAT_INC     = 32'h3C23_7856,
  parameter int unsigned       GAP_CYCLES  = 6,
  parameter int unsigned       TIMEOUT     = 64
) (
  input  wire logic                        axi_clk,
  input  wire logic                        rst_n,
  input  wire logic                        start,
  ddr5_axi_traffic_gen_if.master           bus,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [15:0]                      err_count,
  output logic [$clog2(NUM_TXN+1)-1:0]     txn_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_TXN + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam int unsigned TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TXN - 1);
  // A zero-cycle gap still occupies its state for one cycle.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_RD_WAIT, S_RD_GAP, S_DONE
  } state_e;

  state_e              state_q;
  logic                w_valid_q, r_valid_addr_q, r_ready_q;
  logic [DATA_W-1:0]   w_data_q, pat_data_q;
  logic [ADDR_W-1:0]   w_addr_q, r_addr_q, pat_addr_q;
  logic                busy_q, done_q, pass_q;
  logic [15:0]         err_q;
  logic [IDX_W-1:0]    idx_q;
  logic [GAP_W-1:0]    gap_q;
  logic [TO_W-1:0]     to_q;

  // Pattern for the following index; pat_* always hold the pattern of idx_q,
  // so the running sums replace any multiply.
  logic                last_txn, gap_end, rd_bad;
  logic [IDX_W-1:0]    idx_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d, wdata_first, wdata_d;
  logic [15:0]         err_d;

  assign last_txn = (idx_q == LAST_IDX);
  assign gap_end  = (gap_q == GAP_LAST);
  assign idx_d    = last_txn ? '0        : idx_q + 1'b1;
  assign addr_d   = last_txn ? BASE_ADDR : pat_addr_q + ADDR_STRIDE;
  assign data_d   = last_txn ? PAT_SEED  : pat_data_q + PAT_INC;
  assign err_d    = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
  assign rd_bad   = (bus.R_Data != pat_data_q) || bus.R_Error;

`ifdef TG_ERR_INJECT_EN
  localparam logic [IDX_W-1:0] ERR_INJ_IDX = '0;
  assign wdata_first = (ERR_INJ_IDX == '0) ? {PAT_SEED[DATA_W-1:1], ~PAT_SEED[0]} : PAT_SEED;
  assign wdata_d     = (idx_d == ERR_INJ_IDX) ? {data_d[DATA_W-1:1], ~data_d[0]} : data_d;
`else
  assign wdata_first = PAT_SEED;
  assign wdata_d     = data_d;
`endif

  always_ff @(posedge axi_clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      w_valid_q      <= 1'b0;
      w_data_q       <= '0;
      w_addr_q       <= '0;
      r_valid_addr_q <= 1'b0;
      r_addr_q       <= '0;
      r_ready_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      err_q          <= '0;
      idx_q          <= '0;
      gap_q          <= '0;
      to_q           <= '0;
      pat_addr_q     <= '0;
      pat_data_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_WR_REQ;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            idx_q      <= '0;
            pat_addr_q <= BASE_ADDR;
            pat_data_q <= PAT_SEED;
            w_valid_q  <= 1'b1;
            w_addr_q   <= BASE_ADDR;
            w_data_q   <= wdata_first;
          end
        end
        S_WR_REQ: begin
          if (bus.W_Ready) begin
            w_valid_q <= 1'b0;
            gap_q     <= '0;
            state_q   <= S_WR_GAP;
          end
        end
        S_WR_GAP: begin
          if (gap_end) begin
            idx_q      <= idx_d;
            pat_addr_q <= addr_d;
            pat_data_q <= data_d;
            if (last_txn) begin
              state_q        <= S_RD_REQ;
              r_valid_addr_q <= 1'b1;
              r_addr_q       <= addr_d;
            end else begin
              state_q   <= S_WR_REQ;
              w_valid_q <= 1'b1;
              w_addr_q  <= addr_d;
              w_data_q  <= wdata_d;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_RD_REQ: begin
          if (bus.R_Ready_Address) begin
            r_valid_addr_q <= 1'b0;
            r_ready_q      <= 1'b1;
            to_q           <= '0;
            state_q        <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          // Returned data wins over a timeout expiring on the same cycle.
          if (bus.R_Valid) begin
            if (rd_bad) err_q <= err_d;
            r_ready_q <= 1'b0;
            gap_q     <= '0;
            state_q   <= S_RD_GAP;
          end else if (to_q == TO_LAST) begin
            err_q     <= err_d;
            r_ready_q <= 1'b0;
            gap_q     <= '0;
            state_q   <= S_RD_GAP;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        S_RD_GAP: begin
          if (gap_end) begin
            idx_q      <= idx_d;
            pat_addr_q <= addr_d;
            pat_data_q <= data_d;
            if (last_txn) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_q == 16'd0);
            end else begin
              state_q        <= S_RD_REQ;
              r_valid_addr_q <= 1'b1;
              r_addr_q       <= addr_d;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.W_Valid         = w_valid_q;
  assign bus.W_Data          = w_data_q;
  assign bus.W_STRB          = '1;
  assign bus.W_Address       = w_addr_q;
  assign bus.R_Valid_Address = r_valid_addr_q;
  assign bus.R_Address       = r_addr_q;
  assign bus.R_Ready         = r_ready_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign pass                = pass_q;
  assign err_count           = err_q;
  assign txn_idx             = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr5_axi_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr5_axi_traffic_gen
// Purpose  : Self-checking bench: loopback memory responder with random
//            handshake timing, injected read faults, and a transaction-level
//            model compared against the generator outputs every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr5_axi_traffic_gen;
  localparam int N       = 4;
  localparam int GAP     = 6;
  localparam int TMO     = 64;
  localparam int GAPLEN  = (GAP == 0) ? 1 : GAP;
  localparam logic [31:0] P_BASE = 32'h0000_4567, P_STRIDE = 32'h1;
  localparam logic [31:0] P_SEED = 32'h1425_3679, P_INC = 32'h3C23_7856;
`ifdef TG_ERR_INJECT_EN
  localparam int INJ = 1;
`else
  localparam int INJ = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, busy, done, pass;
  logic [15:0] err_count;
  logic [2:0]  txn_idx;

  ddr5_axi_traffic_gen_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  ddr5_axi_traffic_gen #(.NUM_TXN(N)) dut (
    .axi_clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .txn_idx(txn_idx)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int i);
    return P_BASE + 32'(i) * P_STRIDE;
  endfunction
  function automatic logic [31:0] exp_data(input int i);
    return P_SEED + 32'(i) * P_INC;
  endfunction
  function automatic logic [31:0] exp_wdata(input int i);
    return exp_data(i) ^ ((INJ != 0 && i == 0) ? 32'h1 : 32'h0);
  endfunction

  // ---------------- responder configuration (written by main only) --------
  bit wr_random = 0, rd_random = 0, spurious_en = 0;
  int bp_len = 0;
  int rd_kind [N];   // 0 rand delay, 1 corrupt bit7, 2 R_Error, 3 drop, 4 reply on last cycle, 5 delay 1

  // ---------------- responder state (written by responder only) ----------
  logic [31:0] mem [logic [31:0]];
  bit fresh = 1, rd_pending = 0;
  int wr_seq = 0, rd_seq = 0, bp_cnt = 0, rd_k = 0, rd_cnt = 0, cur_kind = 0, scn_err = 0;
  logic [31:0] rd_addr = '0;
  int wv_cyc [N], rr_cyc [N];
  logic [31:0] wr_log_a [N], wr_log_d [N];

  initial begin
    bus.W_Ready = 1'b0; bus.R_Ready_Address = 1'b0;
    bus.R_Valid = 1'b0; bus.R_Data = '0; bus.R_Error = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy) fresh = 1;
      else if (fresh) begin
        fresh = 0; wr_seq = 0; rd_seq = 0; bp_cnt = 0; rd_pending = 0; scn_err = 0;
        for (int k = 0; k < N; k++) begin
          wv_cyc[k] = 0; rr_cyc[k] = 0; wr_log_a[k] = '0; wr_log_d[k] = '0;
        end
      end
      // write channel
      if (bus.W_Valid && wr_seq == 0 && bp_cnt < bp_len) begin
        bus.W_Ready = 1'b0; bp_cnt++;
      end else bus.W_Ready = wr_random ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.W_Valid && wr_seq < N) wv_cyc[wr_seq]++;
      if (bus.W_Valid && bus.W_Ready) begin
        mem[bus.W_Address] = bus.W_Data;
        if (wr_seq < N) begin wr_log_a[wr_seq] = bus.W_Address; wr_log_d[wr_seq] = bus.W_Data; end
        wr_seq++;
      end
      // read data channel
      bus.R_Valid = 1'b0; bus.R_Error = 1'b0;
      if (bus.R_Ready) begin
        if (rd_seq > 0 && rd_seq <= N) rr_cyc[rd_seq-1]++;
        if (rd_pending) begin
          rd_cnt++;
          if (rd_cnt == rd_k) begin
            bus.R_Valid = 1'b1;
            bus.R_Data  = (mem.exists(rd_addr) ? mem[rd_addr] : 32'hDEAD_BEEF)
                          ^ ((cur_kind == 1) ? 32'h80 : 32'h0);
            bus.R_Error = (cur_kind == 2);
            rd_pending  = 0;
          end
        end
      end else if (spurious_en && $urandom_range(0, 3) == 0) begin
        bus.R_Valid = 1'b1; bus.R_Data = $urandom; bus.R_Error = 1'($urandom_range(0, 1));
      end
      // read address channel
      bus.R_Ready_Address = rd_random ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.R_Valid_Address && bus.R_Ready_Address) begin
        cur_kind   = rd_kind[rd_seq % N];
        rd_k       = (cur_kind == 3) ? 0 : (cur_kind == 4) ? TMO :
                     (cur_kind == 5) ? 1 : $urandom_range(1, 4);
        rd_cnt     = 0; rd_pending = 1; rd_addr = bus.R_Address;
        if (cur_kind inside {1, 2, 3} || (INJ != 0 && rd_seq == 0)) scn_err++;
        rd_seq++;
      end
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------
  bit m_busy = 0, m_done = 0, m_pass = 0, m_rd = 0, m_req = 0, m_wait = 0;
  int m_i = 0, m_quiet = 0, m_wcnt = 0;
  logic [15:0] m_err = '0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_busy = 0; m_done = 0; m_pass = 0; m_rd = 0; m_req = 0; m_wait = 0;
        m_i = 0; m_err = '0; m_quiet = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_done = 0; m_pass = 0; m_i = 0; m_rd = 0; m_req = 1; m_err = '0;
        end
      end else if (m_req) begin
        if (m_rd ? bus.R_Ready_Address : bus.W_Ready) begin
          m_req = 0;
          if (m_rd) begin m_wait = 1; m_wcnt = 0; end
          else m_quiet = GAPLEN;
        end
      end else if (m_wait) begin
        m_wcnt++;
        if (bus.R_Valid) begin
          if ((bus.R_Data !== exp_data(m_i) || bus.R_Error) && m_err != 16'hFFFF) m_err++;
          m_wait = 0; m_quiet = GAPLEN;
        end else if (m_wcnt == TMO) begin
          if (m_err != 16'hFFFF) m_err++;
          m_wait = 0; m_quiet = GAPLEN;
        end
      end else begin
        m_quiet--;
        if (m_quiet == 0) begin
          if (m_i == N - 1) begin
            m_i = 0;
            if (!m_rd) begin m_rd = 1; m_req = 1; end
            else begin m_busy = 0; m_done = 1; m_pass = (m_err == 0); end
          end else begin
            m_i++; m_req = 1;
          end
        end
      end
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("W_Valid", bus.W_Valid, m_busy && !m_rd && m_req);
      chk("R_Valid_Address", bus.R_Valid_Address, m_busy && m_rd && m_req);
      chk("R_Ready", bus.R_Ready, m_busy && m_wait);
      chk("txn_idx", txn_idx, 64'(m_i));
      chk("err_count", err_count, m_err);
      if (m_done) chk("pass", pass, m_pass);
      if (m_busy && !m_rd && m_req) begin
        chk("W_Address", bus.W_Address, exp_addr(m_i));
        chk("W_Data", bus.W_Data, exp_wdata(m_i));
        chk("W_STRB", bus.W_STRB, 4'hF);
      end
      if (m_busy && m_rd && m_req) chk("R_Address", bus.R_Address, exp_addr(m_i));
    end
  end

  // ---------------- directed + random scenarios --------------------------
  task automatic set_kinds(input int k0, input int k1, input int k2, input int k3);
    rd_kind[0] = k0; rd_kind[1] = k1; rd_kind[2] = k2; rd_kind[3] = k3;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_wvalid"}, bus.W_Valid, 0);
    chk({nm, "_rvaddr"}, bus.R_Valid_Address, 0);
    chk({nm, "_rready"}, bus.R_Ready, 0);
    chk({nm, "_wdata"}, bus.W_Data, 0);
    chk({nm, "_waddr"}, bus.W_Address, 0);
    chk({nm, "_raddr"}, bus.R_Address, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass, 0);
    chk({nm, "_err"}, err_count, 0);
    chk({nm, "_idx"}, txn_idx, 0);
  endtask

  task automatic run_once(input string nm, input bit poke_start);
    int c;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (c = 0; c < 3000; c++) begin
      if (done) break;
      start = poke_start ? ($urandom_range(0, 15) == 0) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, "_reached_done"}, done, 1);
    chk({nm, "_err_vs_scenario"}, err_count, 16'(scn_err));
    chk({nm, "_pass_vs_scenario"}, pass, scn_err == 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    set_kinds(5, 5, 5, 5);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // clean loopback, always-ready
    run_once("clean", 0);
    chk("clean_addr0", wr_log_a[0], 32'h0000_4567);
    chk("clean_data0", wr_log_d[0], 32'h1425_3679 ^ 32'(INJ));
    chk("clean_addr1", wr_log_a[1], 32'h0000_4568);
    chk("clean_data1", wr_log_d[1], 32'h5048_AECF);
    chk("clean_wvalid_len0", wv_cyc[0], 1);
    chk("clean_wvalid_len1", wv_cyc[1], 1);
    chk("clean_err_lit", err_count, 16'(INJ));

    // write backpressure on the first write
    bp_len = 5;
    run_once("bp", 0);
    chk("bp_wvalid_len0", wv_cyc[0], 6);
    chk("bp_data0", wr_log_d[0], 32'h1425_3679 ^ 32'(INJ));
    bp_len = 0;

    set_kinds(0, 1, 0, 0); run_once("corrupt1", 0);
    chk("corrupt1_err_lit", err_count, 16'(1 + INJ));
    chk("corrupt1_pass_lit", pass, 0);

    set_kinds(2, 0, 0, 0); run_once("rerr0", 0);
    chk("rerr0_err_lit", err_count, 1);

    set_kinds(0, 0, 3, 0); run_once("drop2", 0);
    chk("drop2_err_lit", err_count, 16'(1 + INJ));
    chk("drop2_wait_len", rr_cyc[2], TMO);

    set_kinds(0, 0, 0, 4); run_once("edge3", 0);
    chk("edge3_err_lit", err_count, 16'(INJ));
    chk("edge3_wait_len", rr_cyc[3], TMO);

    // randomized handshakes, faults, spurious read data and stray starts
    wr_random = 1; rd_random = 1; spurious_en = 1;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 9))
          5: rd_kind[k] = 1;
          6: rd_kind[k] = 2;
          7: rd_kind[k] = 3;
          8: rd_kind[k] = 4;
          9: rd_kind[k] = 5;
          default: rd_kind[k] = 0;
        endcase
      end
      run_once("rand", 1);
    end
    wr_random = 0; rd_random = 0; spurious_en = 0;

    // reset while waiting for read data, then a full replay
    set_kinds(3, 5, 5, 5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (bus.R_Ready) break;
      @(negedge clk);
    end
    chk("midrst_in_rd_wait", bus.R_Ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    set_kinds(5, 5, 5, 5);
    run_once("replay", 0);
    chk("replay_addr0", wr_log_a[0], 32'h0000_4567);
    chk("replay_err_lit", err_count, 16'(INJ));

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
